// File: rtl/goodness_accumulator_pkg.sv
// Shared constants and width helpers for the Forward-Forward goodness accumulator.
package goodness_accumulator_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam int FLUSH_CYCLES = 2;

  function automatic int calc_words(input int neurons, input int parallel);
    return neurons / parallel;
  endfunction

  // Wide enough for either a squared spike count or a positive membrane value.
  function automatic int calc_term_width(input int cnt_w, input int mem_w);
    return (2 * cnt_w > mem_w - 1) ? 2 * cnt_w : mem_w - 1;
  endfunction

endpackage

// File: rtl/goodness_accumulator_if.sv
// Sweep control, lane data and result signals between the SRAM controller and the accumulator.
interface goodness_accumulator_if #(
  parameter int POST_NEUR_PARALLEL        = 4,
  parameter int POST_NEUR_SPIKE_CNT_WIDTH = 7,
  parameter int POST_NEUR_MEM_WIDTH       = 12,
  parameter int GOODNESS_WIDTH            = 24
);

  logic                                                  start;
  logic                                                  label_pos;
  logic                                                  mode;
  logic [GOODNESS_WIDTH-1:0]                             goodness_thr;
  logic                                                  word_valid;
  logic [POST_NEUR_SPIKE_CNT_WIDTH*POST_NEUR_PARALLEL-1:0] post_neur_s_cnt;
  logic [POST_NEUR_MEM_WIDTH*POST_NEUR_PARALLEL-1:0]     post_neur_mem_bus;

  logic                                                  busy;
  logic [GOODNESS_WIDTH-1:0]                             goodness;
  logic                                                  goodness_valid;
  logic                                                  goodness_above;
  logic                                                  train_pot;
  logic                                                  train_dep;
  logic                                                  sat;

  modport master (
    output start, label_pos, mode, goodness_thr, word_valid, post_neur_s_cnt, post_neur_mem_bus,
    input  busy, goodness, goodness_valid, goodness_above, train_pot, train_dep, sat
  );

  modport slave (
    input  start, label_pos, mode, goodness_thr, word_valid, post_neur_s_cnt, post_neur_mem_bus,
    output busy, goodness, goodness_valid, goodness_above, train_pot, train_dep, sat
  );

endinterface

// File: rtl/goodness_accumulator_lane_term.sv
// Per-lane goodness term: squared spike count (mode 0) or ReLU of the membrane (mode 1).
module goodness_lane_term
  import goodness_accumulator_pkg::*;
#(
  parameter int CNT_W  = 7,
  parameter int MEM_W  = 12,
  parameter int TERM_W = calc_term_width(CNT_W, MEM_W)
) (
  input  logic              mode,
  input  logic [CNT_W-1:0]  cnt,
  input  logic [MEM_W-1:0]  mem,
  output logic [TERM_W-1:0] term
);

  logic [2*CNT_W-1:0] sq;

  assign sq = {{CNT_W{1'b0}}, cnt} * {{CNT_W{1'b0}}, cnt};

  always_comb begin
    term = '0;
    if (!mode) begin
      term = TERM_W'(sq);
    end else if (!mem[MEM_W-1]) begin
      term = TERM_W'(mem[MEM_W-2:0]);
    end
  end

endmodule

// File: rtl/goodness_accumulator.sv
// Accumulates per-sample Forward-Forward goodness over all post-neuron SRAM words
// and turns it into potentiate/depress decisions against a programmable threshold.
module goodness_accumulator
  import goodness_accumulator_pkg::*;
#(
  parameter int OUTPUT_NEURON             = 256,
  parameter int POST_NEUR_PARALLEL        = 4,
  parameter int POST_NEUR_SPIKE_CNT_WIDTH = 7,
  parameter int POST_NEUR_MEM_WIDTH       = 12,
  parameter int GOODNESS_WIDTH            = 24
) (
  input logic                   clk,
  input logic                   rst_n,
  goodness_accumulator_if.slave bus
);

  localparam int WORDS  = calc_words(OUTPUT_NEURON, POST_NEUR_PARALLEL);
  localparam int BEAT_W = $clog2(WORDS);
  localparam int TERM_W = calc_term_width(POST_NEUR_SPIKE_CNT_WIDTH, POST_NEUR_MEM_WIDTH);
  localparam int SUM_W  = TERM_W + $clog2(POST_NEUR_PARALLEL);
  localparam int CNT_W  = POST_NEUR_SPIKE_CNT_WIDTH;
  localparam int MEM_W  = POST_NEUR_MEM_WIDTH;

  state_t                    state;
  logic [BEAT_W-1:0]         beat_cnt;
  logic [1:0]                flush_cnt;
  logic                      label_q;
  logic                      mode_q;
  logic [GOODNESS_WIDTH-1:0] thr_q;

  logic [TERM_W-1:0]         lane_term [POST_NEUR_PARALLEL];
  logic [TERM_W-1:0]         term_q    [POST_NEUR_PARALLEL];
  logic                      term_v_q;
  logic [SUM_W-1:0]          beat_sum;
  logic [GOODNESS_WIDTH:0]   acc_sum;
  logic [GOODNESS_WIDTH-1:0] acc;
  logic                      sat_q;

  logic [GOODNESS_WIDTH-1:0] goodness_q;
  logic                      above_q;
  logic                      pot_q;
  logic                      dep_q;

  logic                      accept;
  logic                      flush_last;
  logic                      valid_int;

  assign accept     = (state == ST_ACCUM) && bus.word_valid && !bus.start;
  assign flush_last = (state == ST_FLUSH) && (flush_cnt == 2'(FLUSH_CYCLES - 1));

  for (genvar i = 0; i < POST_NEUR_PARALLEL; i++) begin : g_lane
    goodness_lane_term #(
      .CNT_W  (CNT_W),
      .MEM_W  (MEM_W),
      .TERM_W (TERM_W)
    ) u_term (
      .mode (mode_q),
      .cnt  (bus.post_neur_s_cnt[i*CNT_W +: CNT_W]),
      .mem  (bus.post_neur_mem_bus[i*MEM_W +: MEM_W]),
      .term (lane_term[i])
    );
  end

  // A START anywhere, including the DONE cycle, restarts the sweep and wins over the FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      label_q   <= 1'b0;
      mode_q    <= 1'b0;
      thr_q     <= '0;
    end else if (bus.start) begin
      state     <= ST_ACCUM;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      label_q   <= bus.label_pos;
      mode_q    <= bus.mode;
      thr_q     <= bus.goodness_thr;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (bus.word_valid) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == BEAT_W'(WORDS - 1)) begin
              state     <= ST_FLUSH;
              flush_cnt <= '0;
            end
          end
        end
        ST_FLUSH: begin
          if (flush_last) state <= ST_DONE;
          else            flush_cnt <= flush_cnt + 1'b1;
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < POST_NEUR_PARALLEL; i++) begin
      beat_sum = beat_sum + SUM_W'(term_q[i]);
    end
  end

  assign acc_sum = {1'b0, acc} + (GOODNESS_WIDTH + 1)'(beat_sum);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      term_v_q <= 1'b0;
      acc      <= '0;
      sat_q    <= 1'b0;
      for (int i = 0; i < POST_NEUR_PARALLEL; i++) term_q[i] <= '0;
    end else if (bus.start) begin
      term_v_q <= 1'b0;
      acc      <= '0;
      sat_q    <= 1'b0;
    end else begin
      term_v_q <= accept;
      if (accept) term_q <= lane_term;
      if (term_v_q) begin
        if (acc_sum[GOODNESS_WIDTH]) begin
          acc   <= '1;
          sat_q <= 1'b1;
        end else begin
          acc <= acc_sum[GOODNESS_WIDTH-1:0];
        end
      end
    end
  end

  // The accumulator is final on the last FLUSH cycle, so the result lands as DONE begins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      goodness_q <= '0;
      above_q    <= 1'b0;
      pot_q      <= 1'b0;
      dep_q      <= 1'b0;
    end else if (flush_last && !bus.start) begin
      goodness_q <= acc;
      above_q    <= (acc >= thr_q);
      pot_q      <= label_q && !(acc >= thr_q);
      dep_q      <= !label_q && (acc >= thr_q);
    end
  end

  assign valid_int          = (state == ST_DONE) && !bus.start;
  assign bus.busy           = (state != ST_IDLE);
  assign bus.goodness       = goodness_q;
  assign bus.goodness_valid = valid_int;
  assign bus.goodness_above = above_q;
  assign bus.train_pot      = pot_q && valid_int;
  assign bus.train_dep      = dep_q && valid_int;
  assign bus.sat            = sat_q;

endmodule
